logic_ex_gates: RTL and testbench



---
 rtl/logic_ex_gates.sv | 38 +++
 tb/tb_logic_ex_gates.sv | 111 +++++++++++
 2 files changed

// File: rtl/logic_ex_gates.sv
// logic_ex_gates: two-switch gate demo that synchronizes and debounces SW and drives registered NOT/AND/OR/XOR LEDs
module logic_ex_gates #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] SW,
   output logic [3:0] LED
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [SYNC_STAGES-1:0][1:0] sync_q;
   logic [1:0]    sw_sync, sw_prev, sw_stable;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          accept;
   assign sw_sync = sync_q[SYNC_STAGES-1];
   // the pair is debounced as one vector, so a skewed change restarts the count
   always_comb begin
      cnt_nxt = (sw_sync == sw_prev) ? cnt + 1'b1 : CW'(1);
      accept  = (sw_sync != sw_stable) && (cnt_nxt == CW'(DEBOUNCE_CYCLES));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= '0;
         sw_prev   <= '0;
         sw_stable <= '0;
         cnt       <= '0;
         LED       <= 4'b0001;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], SW};
         sw_prev   <= sw_sync;
         cnt       <= (sw_sync == sw_stable || accept) ? '0 : cnt_nxt;
         sw_stable <= accept ? sw_sync : sw_stable;
         LED       <= {sw_stable[1] ^ sw_stable[0], sw_stable[1] | sw_stable[0],
                       sw_stable[1] & sw_stable[0], ~sw_stable[0]};
      end
   end
endmodule

// File: tb/tb_logic_ex_gates.sv
// tb_logic_ex_gates: random and directed stimulus checked against a history-based reference model
module tb_logic_ex_gates;
   localparam int S = 2;
   localparam int D = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] SW  = 2'b00;
   logic [3:0] LED;
   int checks = 0;
   int errors = 0;
   logic [1:0] pipe [S];
   logic [1:0] yh   [D];
   logic [1:0] stable_m;
   logic [3:0] led_m;
   logic [3:0] lut  [4] = '{4'b0001, 4'b1100, 4'b1101, 4'b0110};

   logic_ex_gates #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .SW(SW), .LED(LED)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
      end
   endtask

   // model: a value is accepted once the synchronized input has shown it for D consecutive cycles
   task automatic step(input logic [1:0] sw, input logic r);
      logic acc;
      SW  = sw;
      rst = r;
      @(posedge clk);
      if (r) begin
         led_m    = 4'b0001;
         stable_m = 2'b00;
         for (int i = 0; i < S; i++) pipe[i] = 2'b00;
         for (int i = 0; i < D; i++) yh[i] = 2'b00;
      end else begin
         acc = (yh[0] != stable_m);
         for (int i = 1; i < D; i++) acc = acc && (yh[i] == yh[0]);
         led_m = lut[stable_m];
         if (acc) stable_m = yh[0];
         for (int i = D - 1; i > 0; i--) yh[i] = yh[i-1];
         for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = sw;
         yh[0]   = pipe[S-1];
      end
      #1 chk("model", LED, led_m);
   endtask

   task automatic hold(input logic [1:0] sw, input int n);
      for (int i = 0; i < n; i++) step(sw, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         step(2'b11, 1'b1);
         chk("reset", LED, 4'b0001);
      end
      for (int i = 0; i < 6; i++) begin
         step(2'b11, 1'b0);
         chk("post_reset_hold", LED, 4'b0001);
      end
      step(2'b11, 1'b0);
      chk("post_reset_value", LED, 4'b0110);
      for (int v = 0; v < 4; v++) begin
         hold(v[1:0], 10);
         chk("sweep", LED, lut[v]);
      end
      hold(2'b00, 10);
      chk("settle_00", LED, 4'b0001);
      for (int i = 0; i < 6; i++) begin
         step(2'b11, 1'b0);
         chk("latency_hold", LED, 4'b0001);
      end
      step(2'b11, 1'b0);
      chk("latency_edge", LED, 4'b0110);
      hold(2'b00, 10);
      hold(2'b01, 2);
      for (int i = 0; i < 10; i++) begin
         step(2'b00, 1'b0);
         chk("glitch", LED, 4'b0001);
      end
      hold(2'b01, 2);
      for (int i = 0; i < 10; i++) begin
         step(2'b11, 1'b0);
         chk("skew_no_1100", {3'b000, LED == 4'b1100}, 4'b0000);
      end
      chk("skew_final", LED, 4'b0110);
      hold(2'b00, 10);
      hold(2'b10, 3);
      step(2'b10, 1'b1);
      chk("mid_reset", LED, 4'b0001);
      for (int i = 0; i < 6; i++) begin
         step(2'b10, 1'b0);
         chk("mid_reset_hold", LED, 4'b0001);
      end
      step(2'b10, 1'b0);
      chk("mid_reset_value", LED, 4'b1101);
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 29) == 0) step(2'($urandom), 1'b1);
         else hold(2'($urandom), $urandom_range(1, 8));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
